seq_player: RTL and testbench

//   Parametrised playback engine for the Simon Says pattern.

---
 rtl/seq_player.sv | 141 ++++++++++++++
 tb/tb_seq_player.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_player.sv
// rtl/seq_player.sv - Simon Says pattern playback engine: fetch symbol, light LED, dark gap, done pulse.
module seq_player #(
    parameter int N_LEDS    = 10,
    parameter int SYM_W     = 2,
    parameter int ADDR_W    = 4,
    parameter int MAX_LEVEL = 15,
    parameter int TIME_W    = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   level,
    input  logic [TIME_W-1:0] on_time,
    input  logic [TIME_W-1:0] gap_time,
    input  logic [SYM_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic [N_LEDS-1:0] led_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_LVL = (ADDR_W + 1)'(MAX_LEVEL);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [N_LEDS-1:0] led_n;
    logic              busy_n, done_n;
    logic [TIME_W-1:0] timer, timer_n;
    logic [TIME_W-1:0] on_q, on_n, gap_q, gap_n;
    logic [ADDR_W:0]   lvl_q, lvl_n;
    logic              last_step;
    logic              sym_ok;

    assign last_step = ({1'b0, rd_addr} == (lvl_q - 1'b1));
    // Symbols beyond the LED count play as a dark step with normal timing.
    assign sym_ok    = (32'(rd_data) < 32'(N_LEDS));

    always_comb begin
        state_n = state;
        addr_n  = rd_addr;
        led_n   = led_out;
        busy_n  = busy;
        done_n  = 1'b0;
        timer_n = timer;
        lvl_n   = lvl_q;
        on_n    = on_q;
        gap_n   = gap_q;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    lvl_n  = (level > MAX_LVL) ? MAX_LVL : level;
                    on_n   = (on_time == '0) ? TIME_W'(1) : on_time;
                    gap_n  = (gap_time == '0) ? TIME_W'(1) : gap_time;
                    addr_n = '0;
                    if (level == '0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = S_FETCH;
                        busy_n  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                state_n = S_ON;
                led_n   = sym_ok ? (N_LEDS'(1) << rd_data) : '0;
                timer_n = on_q - 1'b1;
            end
            S_ON: begin
                if (timer == '0) begin
                    state_n = S_GAP;
                    led_n   = '0;
                    timer_n = gap_q - 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    if (last_step) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        addr_n  = '0;
                    end else begin
                        state_n = S_FETCH;
                        addr_n  = rd_addr + 1'b1;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Abort overrides everything outside IDLE, including a pending done pulse.
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            led_n   = '0;
            busy_n  = 1'b0;
            addr_n  = '0;
            done_n  = 1'b0;
            timer_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            rd_addr <= '0;
            led_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timer   <= '0;
            lvl_q   <= '0;
            on_q    <= '0;
            gap_q   <= '0;
        end else begin
            state   <= state_n;
            rd_addr <= addr_n;
            led_out <= led_n;
            busy    <= busy_n;
            done    <= done_n;
            timer   <= timer_n;
            lvl_q   <= lvl_n;
            on_q    <= on_n;
            gap_q   <= gap_n;
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// tb/tb_seq_player.sv - scoreboard bench for seq_player (10-LED and 3-LED instances side by side).
module tb_seq_player;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  level = '0;
    logic [25:0] on_time = '0;
    logic [25:0] gap_time = '0;
    logic [1:0]  mem [16];
    logic [1:0]  rd_data0, rd_data1;
    logic [3:0]  addr0, addr1;
    logic        busy0, busy1, done0, done1;
    logic [9:0]  led0;
    logic [2:0]  led1;

    assign rd_data0 = mem[addr0];
    assign rd_data1 = mem[addr1];

    seq_player dut0 (
        .clk(clk), .reset(rst), .start(start), .abort(abort), .level(level),
        .on_time(on_time), .gap_time(gap_time), .rd_data(rd_data0),
        .rd_addr(addr0), .busy(busy0), .done(done0), .led_out(led0)
    );

    seq_player #(.N_LEDS(3)) dut3 (
        .clk(clk), .reset(rst), .start(start), .abort(abort), .level(level),
        .on_time(on_time), .gap_time(gap_time), .rd_data(rd_data1),
        .rd_addr(addr1), .busy(busy1), .done(done1), .led_out(led1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] led;
        logic       busy;
        logic       done;
        logic [3:0] addr;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t e0, e1, a0, a1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    function automatic exp_t mk(logic [9:0] l, logic b, logic d, logic [3:0] a);
        exp_t e;
        e.led  = l;
        e.busy = b;
        e.done = d;
        e.addr = a;
        return e;
    endfunction

    function automatic logic [9:0] want_led(logic [1:0] sym, int n);
        return (int'(sym) < n) ? (10'd1 << sym) : 10'd0;
    endfunction

    // Reference trace: one entry per cycle from the cycle start is raised until the done cycle.
    task automatic push_run(int lvl, int on, int gap);
        int l = (lvl > 15) ? 15 : lvl;
        int o = (on < 1) ? 1 : on;
        int g = (gap < 1) ? 1 : gap;
        q0.push_back(mk(10'd0, 1'b0, 1'b0, 4'd0));
        q1.push_back(mk(10'd0, 1'b0, 1'b0, 4'd0));
        for (int k = 0; k < l; k++) begin
            q0.push_back(mk(10'd0, 1'b1, 1'b0, 4'(k)));
            q1.push_back(mk(10'd0, 1'b1, 1'b0, 4'(k)));
            for (int c = 0; c < o; c++) begin
                q0.push_back(mk(want_led(mem[k], 10), 1'b1, 1'b0, 4'(k)));
                q1.push_back(mk(want_led(mem[k], 3), 1'b1, 1'b0, 4'(k)));
            end
            for (int c = 0; c < g; c++) begin
                q0.push_back(mk(10'd0, 1'b1, 1'b0, 4'(k)));
                q1.push_back(mk(10'd0, 1'b1, 1'b0, 4'(k)));
            end
        end
        q0.push_back(mk(10'd0, 1'b0, 1'b1, 4'd0));
        q1.push_back(mk(10'd0, 1'b0, 1'b1, 4'd0));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            e0 = (q0.size() != 0) ? q0.pop_front() : mk(10'd0, 1'b0, 1'b0, 4'd0);
            e1 = (q1.size() != 0) ? q1.pop_front() : mk(10'd0, 1'b0, 1'b0, 4'd0);
            a0 = mk(led0, busy0, done0, addr0);
            a1 = mk({7'd0, led1}, busy1, done1, addr1);
            tests += 2;
            if (a0 !== e0) begin
                fails++;
                $display("FAIL trace10 cyc %0d: got led=%h busy=%b done=%b addr=%0d, want led=%h busy=%b done=%b addr=%0d",
                         cyc, a0.led, a0.busy, a0.done, a0.addr, e0.led, e0.busy, e0.done, e0.addr);
            end
            if (a1 !== e1) begin
                fails++;
                $display("FAIL trace3 cyc %0d: got led=%h busy=%b done=%b addr=%0d, want led=%h busy=%b done=%b addr=%0d",
                         cyc, a1.led, a1.busy, a1.done, a1.addr, e1.led, e1.busy, e1.done, e1.addr);
            end
        end
    end

    task automatic check_reset(string name);
        tests++;
        if ({led0, busy0, done0, addr0} !== '0 || {led1, busy1, done1, addr1} !== '0) begin
            fails++;
            $display("FAIL %s: got led=%h/%h busy=%b/%b done=%b/%b addr=%0d/%0d, want all 0",
                     name, led0, led1, busy0, busy1, done0, done1, addr0, addr1);
        end
    endtask

    task automatic play(int lvl, int on, int gap, int abort_at, int ign_at, int rst_at);
        int i;
        @(posedge clk);
        #1;
        level    = 5'(lvl);
        on_time  = 26'(on);
        gap_time = 26'(gap);
        start    = 1'b1;
        push_run(lvl, on, gap);
        for (i = 1; i < 2000; i++) begin
            @(posedge clk);
            #1;
            start = (i == ign_at);
            abort = (i == abort_at);
            if (i == ign_at) level = 5'd2;
            if (abort) begin
                while (q0.size() > 1) q0.delete(q0.size() - 1);
                while (q1.size() > 1) q1.delete(q1.size() - 1);
            end
            if (i == rst_at) begin
                #1 rst = 1'b1;
                #1 check_reset("async_reset");
                q0.delete();
                q1.delete();
                @(posedge clk);
                #1 rst = 1'b0;
                break;
            end
            if (q0.size() == 0 && q1.size() == 0 && !abort) break;
        end
        tests++;
        if (i >= 2000) begin
            fails++;
            $display("FAIL timeout: run lvl=%0d did not drain in %0d cycles", lvl, i);
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int lvl, on, gap, total, ab, ig;
        foreach (mem[j]) mem[j] = 2'(j % 4);
        mem[4] = 2'd0;
        mem[5] = 2'd1;
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;

        play(6, 3, 2, -1, -1, -1);
        play(0, 3, 2, -1, -1, -1);
        play(6, 3, 2, 15, -1, -1);
        play(6, 3, 2, -1, -1, -1);
        play(6, 3, 2, -1, 10, -1);

        @(posedge clk);
        #1 start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);

        play(6, 3, 2, -1, -1, 3);
        mem[5] = 2'd3;
        play(20, 0, 0, -1, -1, -1);

        repeat (40) begin
            foreach (mem[j]) mem[j] = 2'($urandom);
            lvl   = $urandom_range(0, 20);
            on    = $urandom_range(0, 3);
            gap   = $urandom_range(0, 3);
            total = ((lvl > 15) ? 15 : lvl) * (1 + ((on < 1) ? 1 : on) + ((gap < 1) ? 1 : gap)) + 1;
            ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total) : -1;
            ig    = (total > 3 && $urandom_range(0, 1) == 1) ? $urandom_range(1, total - 2) : -1;
            if (ab != -1 && ig >= ab) ig = -1;
            play(lvl, on, gap, ab, ig, -1);
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
